// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that sequences whole-line read/write transfers of two caches onto the C2 memory bus.
// Defining MEM_ARB_TIMEOUT_EN adds a wait-state timeout that completes a stalled transfer with rq_err set.
`timescale 1ns/1ps
module mem_bus_arbiter #(
    parameter int BUS_SIZE          = 16,
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int CACHE_LINE_SIZE   = 16,
    parameter int TIMEOUT           = 255
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [1:0]                                        rq_req,
    input  logic [1:0]                                        rq_write,
    input  logic [2*(MEM_ADDR_SIZE-CACHE_OFFSET_SIZE)-1:0]    rq_addr,
    input  logic [2*CACHE_LINE_SIZE*8-1:0]                    rq_wline,
    output logic [CACHE_LINE_SIZE*8-1:0]                      rq_rline,
    output logic [1:0]                                        rq_done,
    output logic                                              rq_err,
    output logic [1:0]                                        rq_grant,
    output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0]        mem_address,
    inout  wire  [BUS_SIZE-1:0]                               mem_data,
    inout  wire  [1:0]                                        mem_command
);

    localparam int LINE   = CACHE_LINE_SIZE * 8;
    localparam int BEATS  = LINE / BUS_SIZE;
    localparam int ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if ((LINE % BUS_SIZE) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("mem_bus_arbiter: line must split evenly into bus beats and TIMEOUT must be positive");
    end

    typedef enum logic [1:0] {
        CMD_NOP      = 2'd0,
        CMD_RESPONSE = 2'd1,
        CMD_READ     = 2'd2,
        CMD_WRITE    = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_WAIT,
        S_WR_BEAT,
        S_WR_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE-1:0]   wline_q, wline_d;
    logic [LINE-1:0]   rbuf_q, rbuf_d;
    logic [LINE-1:0]   rline_q, rline_d;
    logic [CNT_W-1:0]  beat_q, beat_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
`endif

    logic       pick;
    logic       respSeen;
    logic       cmdOe;
    logic       dataOe;
    logic [1:0] cmdOut;

    always_comb begin
        pick = rq_req[1];
        if (rq_req == 2'b11) begin
            pick = ~last_q;
        end
    end

    assign respSeen = (mem_command == CMD_RESPONSE);

    // Next-state logic; the read line is assembled in rbuf and committed to rq_rline on completion.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        write_d = write_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rbuf_d  = rbuf_q;
        rline_d = rline_q;
        beat_d  = beat_q;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_d  = wait_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|rq_req) begin
                    grant_d = pick ? 2'b10 : 2'b01;
                    last_d  = pick;
                    write_d = rq_write[pick];
                    addr_d  = rq_addr[pick*ADDR_W +: ADDR_W];
                    if (rq_write[pick]) begin
                        wline_d = rq_wline[pick*LINE +: LINE];
                    end
                    rbuf_d  = rline_q;
                    beat_d  = '0;
                    state_d = rq_write[pick] ? S_WR_BEAT : S_RD_CMD;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_RD_CMD: begin
                beat_d  = '0;
                state_d = S_RD_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            S_RD_WAIT: begin
                if (respSeen) begin
                    rbuf_d[BUS_SIZE*beat_q +: BUS_SIZE] = mem_data;
                    if (beat_q == LAST_BEAT) begin
                        rline_d = rbuf_d;
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_d = '0;
                end else if (wait_q == WAIT_LAST) begin
                    rline_d = rbuf_q;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
`endif
                end
            end
            S_WR_BEAT: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = S_WR_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_WR_WAIT: begin
                if (respSeen) begin
                    state_d = S_DONE;
`ifdef MEM_ARB_TIMEOUT_EN
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
`endif
                end
            end
            S_DONE: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    // last_q resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            write_q <= 1'b0;
            addr_q  <= '0;
            wline_q <= '0;
            rbuf_q  <= '0;
            rline_q <= '0;
            beat_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rbuf_q  <= rbuf_d;
            rline_q <= rline_d;
            beat_q  <= beat_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_q  <= wait_d;
            err_q   <= err_d;
`endif
        end
    end

    // Bus drive is decoded from the current state so an async reset releases the bus immediately.
    always_comb begin
        cmdOe  = 1'b0;
        dataOe = 1'b0;
        cmdOut = CMD_NOP;
        if (state_q == S_RD_CMD) begin
            cmdOe  = 1'b1;
            cmdOut = CMD_READ;
        end else if (state_q == S_WR_BEAT) begin
            cmdOe  = 1'b1;
            dataOe = 1'b1;
            cmdOut = CMD_WRITE;
        end
    end

    assign mem_command = cmdOe  ? cmdOut : 2'bzz;
    assign mem_data    = dataOe ? wline_q[BUS_SIZE*beat_q +: BUS_SIZE] : {BUS_SIZE{1'bz}};
    assign mem_address = addr_q;
    assign rq_grant    = grant_q;
    assign rq_done     = (state_q == S_DONE) ? grant_q : 2'b00;
    assign rq_rline    = rline_q;

`ifdef MEM_ARB_TIMEOUT_EN
    assign rq_err = (state_q == S_DONE) && err_q;
`else
    assign rq_err = 1'b0;
`endif

    // write_q is kept for visibility of the current direction; the FSM path already encodes it.
    logic unusedWrite;
    assign unusedWrite = write_q;

endmodule
